niosii_sys_nios2_gen2_0_cpu_div_cell: RTL and testbench



---
 rtl/niosii_sys_nios2_gen2_0_cpu_div_cell.sv | 125 ++++++++++++
 tb/tb_niosii_sys_nios2_gen2_0_cpu_div_cell.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/niosii_sys_nios2_gen2_0_cpu_div_cell.sv
// Iterative radix-2 restoring divider for the Nios II execute pipeline.
// Accepts a dividend/divisor pair in IDLE, produces one quotient bit per
// cycle in CALC, applies the sign fix-up in FIX and strobes M_div_done with
// registered quotient and remainder. Fixed latency of WIDTH+2 cycles from the
// accepting edge, including divide-by-zero.
module niosii_sys_nios2_gen2_0_cpu_div_cell #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] E_src1,
  input  logic [WIDTH-1:0] E_src2,
  input  logic             E_div_signed,
  input  logic             E_div_start,
  output logic             M_div_busy,
  output logic             M_div_done,
  output logic [WIDTH-1:0] M_div_quot,
  output logic [WIDTH-1:0] M_div_rem
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] prem;     // partial remainder
  logic [WIDTH-1:0] dvd;      // dividend bits shifting out, quotient bits shifting in
  logic [WIDTH-1:0] divisor;
  logic             q_neg;
  logic             r_neg;

  logic             src1_neg;
  logic             src2_neg;
  logic             src2_zero;
  logic [WIDTH-1:0] src1_mag;
  logic [WIDTH-1:0] src2_mag;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;

  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  // Operand conditioning: magnitudes and sign flags for the accepting edge.
  // The most negative value negates to itself and is read as unsigned 2^(W-1).
  always_comb begin
    src1_neg  = E_div_signed & E_src1[WIDTH-1];
    src2_neg  = E_div_signed & E_src2[WIDTH-1];
    src2_zero = (E_src2 == '0);
    src1_mag  = src1_neg ? -E_src1 : E_src1;
    src2_mag  = src2_neg ? -E_src2 : E_src2;
  end

  // One restoring step. prem stays below 2^(W-1) before every shift, so
  // dropping prem[W-1] loses nothing; bit W of the subtract is the borrow.
  always_comb begin
    shifted = {prem[WIDTH-2:0], dvd[WIDTH-1]};
    trial   = {1'b0, shifted} - {1'b0, divisor};
    borrow  = trial[WIDTH];
  end

  // Sign fix-up applied to the finished magnitudes.
  always_comb begin
    quot_fix = q_neg ? -dvd  : dvd;
    rem_fix  = r_neg ? -prem : prem;
  end

  // Sequencer and datapath registers; reset wins over a same-cycle start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      prem       <= '0;
      dvd        <= '0;
      divisor    <= '0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      M_div_busy <= 1'b0;
      M_div_done <= 1'b0;
      M_div_quot <= '0;
      M_div_rem  <= '0;
    end else begin
      M_div_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (E_div_start) begin
            state      <= ST_CALC;
            M_div_busy <= 1'b1;
            cnt        <= CW'(WIDTH - 1);
            prem       <= '0;
            dvd        <= src1_mag;
            divisor    <= src2_mag;
            q_neg      <= (src1_neg ^ src2_neg) & ~src2_zero;
            r_neg      <= src1_neg;
          end
        end
        ST_CALC: begin
          prem <= borrow ? shifted : trial[WIDTH-1:0];
          dvd  <= {dvd[WIDTH-2:0], ~borrow};
          if (cnt == '0) begin
            state <= ST_FIX;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_FIX: begin
          M_div_quot <= quot_fix;
          M_div_rem  <= rem_fix;
          M_div_done <= 1'b1;
          M_div_busy <= 1'b0;
          state      <= ST_IDLE;
        end
        default: begin
          state      <= ST_IDLE;
          M_div_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_niosii_sys_nios2_gen2_0_cpu_div_cell.sv
// Self-checking bench for the iterative divider: directed scenarios plus
// randomized operations compared against a plain-arithmetic reference model.
module tb_niosii_sys_nios2_gen2_0_cpu_div_cell;

  logic        clk;
  logic        reset;
  logic [31:0] E_src1;
  logic [31:0] E_src2;
  logic        E_div_signed;
  logic        E_div_start;
  logic        M_div_busy;
  logic        M_div_done;
  logic [31:0] M_div_quot;
  logic [31:0] M_div_rem;

  int checks = 0;
  int errors = 0;

  niosii_sys_nios2_gen2_0_cpu_div_cell #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .E_src1       (E_src1),
    .E_src2       (E_src2),
    .E_div_signed (E_div_signed),
    .E_div_start  (E_div_start),
    .M_div_busy   (M_div_busy),
    .M_div_done   (M_div_done),
    .M_div_quot   (M_div_quot),
    .M_div_rem    (M_div_rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: truncating division, remainder takes dividend sign;
  // divide by zero gives all-ones quotient and the dividend as remainder.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  input logic s, output logic [31:0] q,
                                  output logic [31:0] r);
    longint sa;
    longint sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  function automatic logic [31:0] rnd_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'd0;
      1:       v = 32'h8000_0000;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'($urandom_range(1, 15));
      4:       v = 32'(0 - $urandom_range(1, 15));
      5:       v = 32'($urandom_range(0, 65535));
      default: v = $urandom();
    endcase
    return v;
  endfunction

  // Drive a start in the current cycle (T); returns at the negedge of T+1.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    E_src1       = a;
    E_src2       = b;
    E_div_signed = s;
    E_div_start  = 1'b1;
    @(negedge clk);
    E_div_start  = 1'b0;
  endtask

  // From T+1, step until done is seen; lat is the cycle offset from T.
  task automatic wait_done(output int lat, output bit seen);
    lat  = 1;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (M_div_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    E_div_start  = 1'b0;
    E_src1       = '0;
    E_src2       = '0;
    E_div_signed = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (M_div_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", M_div_busy); end
    checks++; if (M_div_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", M_div_done); end
    checks++; if (M_div_quot !== 32'd0) begin errors++; $display("FAIL reset_quot: got %h want 0", M_div_quot); end
    checks++; if (M_div_rem  !== 32'd0) begin errors++; $display("FAIL reset_rem: got %h want 0", M_div_rem); end
    // reset and start together: reset wins, start is not remembered
    E_src1 = 32'd100; E_src2 = 32'd7; E_div_start = 1'b1;
    @(negedge clk);
    reset = 1'b0; E_div_start = 1'b0;
    checks++; if (M_div_busy !== 1'b0) begin errors++; $display("FAIL reset_prio_busy: got %b want 0", M_div_busy); end
    @(negedge clk);
    checks++; if (M_div_busy !== 1'b0) begin errors++; $display("FAIL reset_prio_busy2: got %b want 0", M_div_busy); end
  endtask

  task automatic test_unsigned();
    logic exp_busy;
    logic exp_done;
    start_op(32'd100, 32'd7, 1'b0);
    for (int k = 1; k <= 34; k++) begin
      exp_busy = (k <= 33);
      exp_done = (k == 34);
      checks++; if (M_div_busy !== exp_busy) begin errors++; $display("FAIL unsigned_busy c%0d: got %b want %b", k, M_div_busy, exp_busy); end
      checks++; if (M_div_done !== exp_done) begin errors++; $display("FAIL unsigned_done c%0d: got %b want %b", k, M_div_done, exp_done); end
      if (k < 34) @(negedge clk);
    end
    checks++; if (M_div_quot !== 32'd14) begin errors++; $display("FAIL unsigned_quot: got %h want %h", M_div_quot, 32'd14); end
    checks++; if (M_div_rem  !== 32'd2)  begin errors++; $display("FAIL unsigned_rem: got %h want %h", M_div_rem, 32'd2); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (M_div_done !== 1'b0) begin errors++; $display("FAIL hold_done: got %b want 0", M_div_done); end
      checks++; if ({M_div_quot, M_div_rem} !== {32'd14, 32'd2}) begin errors++; $display("FAIL hold_result: got %h/%h want 0000000e/00000002", M_div_quot, M_div_rem); end
    end
  endtask

  task automatic test_corners();
    logic [31:0] ca[8];
    logic [31:0] cb[8];
    logic [31:0] cq[8];
    logic [31:0] cr[8];
    logic        cs[8];
    int          lat;
    bit          seen;
    ca[0] = 32'hFFFF_FFF9; cb[0] = 32'h0000_0002; cs[0] = 1'b1; cq[0] = 32'hFFFF_FFFD; cr[0] = 32'hFFFF_FFFF;
    ca[1] = 32'h0000_0007; cb[1] = 32'hFFFF_FFFE; cs[1] = 1'b1; cq[1] = 32'hFFFF_FFFD; cr[1] = 32'h0000_0001;
    ca[2] = 32'h1234_5678; cb[2] = 32'h0000_0000; cs[2] = 1'b0; cq[2] = 32'hFFFF_FFFF; cr[2] = 32'h1234_5678;
    ca[3] = 32'h8000_0000; cb[3] = 32'hFFFF_FFFF; cs[3] = 1'b1; cq[3] = 32'h8000_0000; cr[3] = 32'h0000_0000;
    ca[4] = 32'hFFFF_FFFF; cb[4] = 32'h0000_0001; cs[4] = 1'b0; cq[4] = 32'hFFFF_FFFF; cr[4] = 32'h0000_0000;
    ca[5] = 32'hFFFF_FFFB; cb[5] = 32'h0000_0000; cs[5] = 1'b1; cq[5] = 32'hFFFF_FFFF; cr[5] = 32'hFFFF_FFFB;
    ca[6] = 32'h8000_0000; cb[6] = 32'hFFFF_FFFF; cs[6] = 1'b0; cq[6] = 32'h0000_0000; cr[6] = 32'h8000_0000;
    ca[7] = 32'hFFFF_FFF9; cb[7] = 32'hFFFF_FFFE; cs[7] = 1'b1; cq[7] = 32'h0000_0003; cr[7] = 32'hFFFF_FFFF;
    for (int i = 0; i < 8; i++) begin
      start_op(ca[i], cb[i], cs[i]);
      wait_done(lat, seen);
      checks++; if (!seen || lat != 34) begin errors++; $display("FAIL corner%0d_latency: got %0d (seen %0d) want 34", i, lat, seen); end
      checks++; if (M_div_quot !== cq[i]) begin errors++; $display("FAIL corner%0d_quot: got %h want %h", i, M_div_quot, cq[i]); end
      checks++; if (M_div_rem  !== cr[i]) begin errors++; $display("FAIL corner%0d_rem: got %h want %h", i, M_div_rem, cr[i]); end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic exp_done;
    int   lat;
    bit   seen;
    start_op(32'd50, 32'd5, 1'b0);
    for (int k = 1; k <= 34; k++) begin
      if (k == 10) begin
        E_src1 = 32'd9; E_src2 = 32'd3; E_div_start = 1'b1;
      end else begin
        E_div_start = 1'b0;
      end
      exp_done = (k == 34);
      checks++; if (M_div_done !== exp_done) begin errors++; $display("FAIL busy_start_done c%0d: got %b want %b", k, M_div_done, exp_done); end
      if (k < 34) @(negedge clk);
    end
    checks++; if ({M_div_quot, M_div_rem} !== {32'd10, 32'd0}) begin errors++; $display("FAIL busy_start_result: got %h/%h want 0000000a/00000000", M_div_quot, M_div_rem); end
    start_op(32'd9, 32'd3, 1'b0);
    wait_done(lat, seen);
    checks++; if (!seen || lat != 34) begin errors++; $display("FAIL b2b_latency: got %0d (seen %0d) want 34", lat, seen); end
    checks++; if ({M_div_quot, M_div_rem} !== {32'd3, 32'd0}) begin errors++; $display("FAIL b2b_result: got %h/%h want 00000003/00000000", M_div_quot, M_div_rem); end
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    int ndone;
    int nbusy;
    int lat;
    bit seen;
    start_op(32'd1000, 32'd3, 1'b0);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (M_div_busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", M_div_busy); end
    checks++; if (M_div_done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b want 0", M_div_done); end
    checks++; if (M_div_quot !== 32'd0) begin errors++; $display("FAIL midreset_quot: got %h want 0", M_div_quot); end
    checks++; if (M_div_rem  !== 32'd0) begin errors++; $display("FAIL midreset_rem: got %h want 0", M_div_rem); end
    ndone = 0;
    nbusy = 0;
    for (int k = 0; k < 40; k++) begin
      if (M_div_done !== 1'b0) ndone++;
      if (M_div_busy !== 1'b0) nbusy++;
      @(negedge clk);
    end
    checks++; if (ndone != 0) begin errors++; $display("FAIL midreset_no_done: got %0d strobes want 0", ndone); end
    checks++; if (nbusy != 0) begin errors++; $display("FAIL midreset_no_busy: got %0d busy cycles want 0", nbusy); end
    start_op(32'd1000, 32'd3, 1'b0);
    wait_done(lat, seen);
    checks++; if (!seen || lat != 34) begin errors++; $display("FAIL midreset_fresh_latency: got %0d (seen %0d) want 34", lat, seen); end
    checks++; if ({M_div_quot, M_div_rem} !== {32'd333, 32'd1}) begin errors++; $display("FAIL midreset_fresh_result: got %h/%h want 0000014d/00000001", M_div_quot, M_div_rem); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] eq;
    logic [31:0] er;
    int          gap;
    int          jpos;
    int          lat;
    bit          seen;
    for (int n = 0; n < 1200; n++) begin
      a    = rnd_operand();
      b    = rnd_operand();
      s    = 1'($urandom_range(0, 1));
      gap  = int'($urandom_range(0, 3));
      jpos = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 30)) : 0;
      repeat (gap) @(negedge clk);
      start_op(a, b, s);
      // optional stray start with junk operands while busy
      lat  = 1;
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
        if (M_div_done === 1'b1) begin
          seen = 1'b1;
          break;
        end
        if (lat == jpos) begin
          E_src1 = $urandom(); E_src2 = $urandom(); E_div_signed = ~s; E_div_start = 1'b1;
        end else begin
          E_div_start = 1'b0;
        end
        @(negedge clk);
        lat++;
      end
      E_div_start = 1'b0;
      ref_div(a, b, s, eq, er);
      checks++; if (!seen || lat != 34) begin errors++; $display("FAIL rand%0d_latency: got %0d (seen %0d) want 34", n, lat, seen); end
      checks++; if ({M_div_quot, M_div_rem} !== {eq, er}) begin errors++; $display("FAIL rand%0d_result s=%b %h/%h: got %h/%h want %h/%h", n, s, a, b, M_div_quot, M_div_rem, eq, er); end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_corners();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
